// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared pipeline types and fetch constants
package fetch_unit_pkg;

  typedef struct packed {
    logic [8:0]  Curr_Pc;
    logic [31:0] Curr_Instr;
  } if_id_reg;

  localparam logic [31:0] FETCH_NOP = 32'h0000_0013;
  localparam logic [8:0]  PC_STEP   = 9'd4;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  function automatic if_id_reg fetch_bubble();
    if_id_reg b;
    b.Curr_Pc    = 9'h000;
    b.Curr_Instr = FETCH_NOP;
    return b;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// rtl/fetch_unit_pc_counter.sv - 9-bit program counter with load, hold and step
module pc_counter
  import fetch_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       hold,
  input  logic [8:0] load_value,
  output logic [8:0] pc
);

  // Load beats hold so a redirect during a stall still takes effect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= 9'h000;
    end else if (load) begin
      pc <= load_value;
    end else if (!hold) begin
      pc <= pc + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with RUN/HALTED control and IF/ID register
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        pc_sel,
  input  logic [8:0]  branch_target,
  input  logic        halt_req,
  output logic [8:0]  imem_addr,
  input  logic [31:0] imem_rdata,
  output if_id_reg    if_id_q,
  output logic        halted,
  output logic [31:0] fetch_count
);

  fetch_state_e state;
  logic [8:0]   pc;
  logic [8:0]   target_aligned;
  logic         pc_load;
  logic         pc_hold;

  assign target_aligned = branch_target & ~9'h003;
  assign imem_addr      = pc;

  // Halt outranks redirect, redirect outranks stall.
  assign pc_load = (state == RUN) && !halt_req && pc_sel;
  assign pc_hold = (state == HALTED) || halt_req || stall;

  pc_counter u_pc (
    .clk        (clk),
    .reset      (reset),
    .load       (pc_load),
    .hold       (pc_hold),
    .load_value (target_aligned),
    .pc         (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      if_id_q     <= fetch_bubble();
      halted      <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      case (state)
        RUN: begin
          if (halt_req) begin
            state   <= HALTED;
            halted  <= 1'b1;
            if_id_q <= fetch_bubble();
          end else if (pc_sel) begin
            if_id_q <= fetch_bubble();
          end else if (!stall) begin
            if_id_q.Curr_Pc    <= pc;
            if_id_q.Curr_Instr <= imem_rdata;
            fetch_count        <= fetch_count + 32'd1;
          end
        end
        HALTED: begin
          if_id_q <= fetch_bubble();
          halted  <= 1'b1;
        end
        default: begin
          state   <= RUN;
          if_id_q <= fetch_bubble();
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-003 SHALL have port: stall  in  1  load-use stall from hazard unit; hold PC and IF/ID.
REQ-004 SHALL have port: pc_sel  in  1  taken branch/jump resolved in EX; redirect fetch.
REQ-005 SHALL have port: branch_target  in  9  redirect byte address from EX.
REQ-006 SHALL have port: halt_req  in  1  Halt bit of the ID/EX register; stop fetching.
REQ-007 SHALL have port: imem_addr  out  9  instruction memory byte address, equal to the current PC.
REQ-008 SHALL have port: imem_rdata  in  32  combinational instruction read data for imem_addr.
REQ-009 SHALL have port: if_id_q  out  if_id_reg  IF/ID register output {Curr_Pc, Curr_Instr}.
REQ-010 SHALL have port: halted  out  1  high while in state HALTED.
REQ-011 SHALL have port: fetch_count  out  32  number of real (non-bubble) instructions loaded into IF/ID.

Function
REQ-012 SHALL hold a 9-bit PC; imem_addr = PC combinationally.
REQ-013 SHALL implement a two-state FSM: RUN and HALTED.
REQ-014 RUN, normal cycle: PC <= PC + 4 (mod 512); if_id_q <= {PC, imem_rdata}; fetch_count += 1.
REQ-015 PC arithmetic SHALL wrap: PC = 0x1FC advances to 0x000.
REQ-016 RUN with pc_sel=1: PC <= {branch_target[8:2], 2'b00}; if_id_q <= bubble; fetch_count unchanged.
REQ-017 RUN with stall=1 and pc_sel=0: PC, if_id_q and fetch_count SHALL hold.
REQ-018 RUN with halt_req=1: next state HALTED; PC holds; if_id_q <= bubble; fetch_count unchanged.
REQ-019 Priority within RUN SHALL be: halt_req > pc_sel > stall > normal.
REQ-020 halt_req and pc_sel together SHALL give halt behaviour; pc_sel and stall together SHALL give redirect behaviour.
REQ-021 HALTED SHALL be exited only by reset; PC frozen; if_id_q held at bubble; all inputs except reset ignored.
REQ-022 Bubble SHALL be {Curr_Pc = 9'h000, Curr_Instr = FETCH_NOP (32'h0000_0013)}.
REQ-023 fetch_count SHALL wrap modulo 2^32.
REQ-024 Latency: an instruction at PC appears on if_id_q one clk after it is addressed, absent stall, redirect or halt.
REQ-025 halted SHALL be registered and go high on the edge that enters HALTED.

Reset
REQ-026 reset=1 at a clk edge SHALL force PC = 0x000, state = RUN, if_id_q = bubble, halted = 0, fetch_count = 0.
REQ-027 reset SHALL override every other input, including in HALTED and during stall.
REQ-028 Fetch of address 0x000 SHALL begin on the first edge with reset low.

Structure
REQ-029 The shared pipeline package SHALL add the constants FETCH_NOP (32'h0000_0013) and PC_STEP (9'd4) and the enum fetch_state_e {RUN, HALTED}; the block SHALL reuse if_id_reg unchanged.
REQ-030 The PC SHALL be a sub-module pc_counter (load, hold, increment-by-4, synchronous reset); the FSM, IF/ID register and counter SHALL sit in fetch_unit.

Verification
REQ-031 Sequential fetch: reset, then 3 idle cycles with imem returning 0xA0, 0xA4, 0xA8 -> if_id_q.Curr_Pc = 0x000, 0x004, 0x008 in successive cycles; fetch_count = 3.
REQ-032 Redirect plus stall: PC = 0x010, pc_sel=1, stall=1, target = 0x043 -> next PC = 0x040; if_id_q = bubble; fetch_count unchanged.
REQ-033 Stall: stall=1 for 2 cycles at PC = 0x020 -> PC, if_id_q and fetch_count unchanged for 2 cycles; normal fetch resumes at 0x020.
REQ-034 Wrap: PC = 0x1FC, idle -> next PC = 0x000; if_id_q.Curr_Pc = 0x1FC.
REQ-035 Halt: halt_req=1 together with pc_sel=1 at PC = 0x030 -> halted=1; PC stays 0x030 while pc_sel and stall toggle.
REQ-036 Reset mid-operation: reset while HALTED at PC = 0x030 with fetch_count = 12 -> PC = 0, halted = 0, fetch_count = 0, if_id_q = bubble.
